// File: rtl/digit_uart_reporter.sv
// digit_uart_reporter: reads the predicted digit after each inference, turns
// it into ASCII (optionally followed by CR LF) and sends it as 8N1 UART.
// tx, sent and busy-release are registered one cycle behind the state
// machine. This keeps tx glitch-free and places every output edge exactly
// one clock after the state edge that causes it.
module digit_uart_reporter #(
  parameter int CLKS_PER_BIT = 868,
  parameter bit SEND_CRLF    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inference_done,
  output logic       ram_rd_addr,
  input  logic [7:0] ram_rd_data,
  output logic       tx,
  output logic       busy,
  output logic       sent
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_CAP, START, DATA, STOP} state_t;

  state_t        state, next_state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [1:0]    msg_len;
  logic [7:0]    char0;
  logic          pending;
  logic          fin;

  logic          bit_end;
  logic          last_byte;
  logic          last_stop;
  logic          accept;
  logic [7:0]    cur_byte;

  // Digits map to '0'..'9'; any out-of-range nibble is reported as '?'.
  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    if (d <= 4'd9) return 8'h30 + {4'h0, d};
    else           return 8'h3F;
  endfunction

  assign ram_rd_addr = 1'b0;
  assign bit_end     = (clk_cnt == CNT_LAST);
  assign last_byte   = (byte_idx == msg_len - 2'd1);
  assign last_stop   = (state == STOP) && bit_end && last_byte;
  assign accept      = (state == IDLE) && (inference_done || pending);

  // Byte currently on the wire: the digit, then CR, then LF.
  always_comb begin
    cur_byte = char0;
    if (byte_idx == 2'd1)      cur_byte = 8'h0D;
    else if (byte_idx == 2'd2) cur_byte = 8'h0A;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (inference_done || pending) next_state = RD_WAIT;
      RD_WAIT: next_state = RD_CAP;
      RD_CAP:  next_state = START;
      START:   if (bit_end) next_state = DATA;
      DATA:    if (bit_end && bit_idx == 3'd7) next_state = STOP;
      STOP:    if (bit_end) next_state = last_byte ? IDLE : START;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Bit-time counter, bit/byte indices and captured message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      msg_len  <= '0;
      char0    <= '0;
    end else begin
      if (state == START || state == DATA || state == STOP)
        clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
      else
        clk_cnt <= '0;
      if (state == START)                bit_idx <= '0;
      else if (state == DATA && bit_end) bit_idx <= bit_idx + 3'd1;
      if (state == RD_CAP) begin
        char0    <= to_ascii(ram_rd_data[3:0]);
        msg_len  <= SEND_CRLF ? 2'd3 : 2'd1;
        byte_idx <= '0;
      end else if (state == STOP && bit_end && !last_byte) begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  // Registered line driver and completion handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx      <= 1'b1;
      fin     <= 1'b0;
      sent    <= 1'b0;
      busy    <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (state == START)     tx <= 1'b0;
      else if (state == DATA) tx <= cur_byte[bit_idx];
      else                    tx <= 1'b1;
      fin  <= last_stop;
      sent <= fin;
      if (accept)   busy <= 1'b1;
      else if (fin) busy <= 1'b0;
      if (accept)              pending <= 1'b0;
      else if (inference_done) pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_digit_uart_reporter.sv
// Bench for digit_uart_reporter: a CR/LF instance and a bare-digit instance
// at 4 clocks per bit, each with a registered RAM model and a UART receiver
// scoreboard.
module tb_digit_uart_reporter;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       done_a, done_b;
  logic [7:0] wdata_a, wdata_b;
  logic [7:0] mem_a, mem_b, rd_a, rd_b;
  logic       addr_a, addr_b;
  logic       tx_a, tx_b, busy_a, busy_b, sent_a, sent_b;

  int checks = 0;
  int errors = 0;
  int rst_events = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  always #5 clk = ~clk;

  digit_uart_reporter #(.CLKS_PER_BIT(CPB), .SEND_CRLF(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .inference_done(done_a), .ram_rd_addr(addr_a),
    .ram_rd_data(rd_a), .tx(tx_a), .busy(busy_a), .sent(sent_a));

  digit_uart_reporter #(.CLKS_PER_BIT(CPB), .SEND_CRLF(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .inference_done(done_b), .ram_rd_addr(addr_b),
    .ram_rd_data(rd_b), .tx(tx_b), .busy(busy_b), .sent(sent_b));

  // predicted_digit_ram models: write on the done pulse, 1-cycle registered read.
  always @(posedge clk) begin
    if (done_a) mem_a <= wdata_a;
    if (done_b) mem_b <= wdata_b;
    rd_a <= mem_a;
    rd_b <= mem_b;
  end

  always @(negedge rst_n) rst_events++;

  // UART receiver: decodes one frame mid-bit and scores it against the queue.
  task automatic rx_frame(input int which);
    logic [7:0] got, exp;
    logic       st, sp;
    int         rc;
    if (which == 0) @(negedge tx_a); else @(negedge tx_b);
    if (rst_n) begin
      rc = rst_events;
      repeat (CPB / 2) @(posedge clk);
      #1 st = (which == 0) ? tx_a : tx_b;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        #1 got[i] = (which == 0) ? tx_a : tx_b;
      end
      repeat (CPB) @(posedge clk);
      #1 sp = (which == 0) ? tx_a : tx_b;
      if (rc == rst_events) begin
        checks++;
        if ((which == 0 && q_a.size() == 0) || (which == 1 && q_b.size() == 0)) begin
          errors++;
          $display("FAIL frame_%0d unexpected frame got %h", which, got);
        end else begin
          exp = (which == 0) ? q_a.pop_front() : q_b.pop_front();
          if (got !== exp || st !== 1'b0 || sp !== 1'b1) begin
            errors++;
            $display("FAIL frame_%0d got %h start %b stop %b expected %h start 0 stop 1",
                     which, got, st, sp, exp);
          end
        end
      end
    end
  endtask

  initial forever rx_frame(0);
  initial forever rx_frame(1);

  // Pulses inference_done for one cycle; returns 1ns after edge N.
  task automatic pulse(input int which, input logic [7:0] d);
    if (which == 0) begin done_a = 1'b1; wdata_a = d; end
    else            begin done_b = 1'b1; wdata_b = d; end
    @(posedge clk);
    #1;
    done_a = 1'b0;
    done_b = 1'b0;
  endtask

  // Observes ncyc edges after N; k counts edges since the pulse.
  task automatic watch(input int which, input int ncyc, output int first_s,
                       output int second_s, output int nsent, output int busy_low,
                       output logic tx2, output logic tx3);
    logic s, b, t;
    first_s = -1; second_s = -1; nsent = 0; busy_low = -1; tx2 = 1'bx; tx3 = 1'bx;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      #1;
      s = (which == 0) ? sent_a : sent_b;
      b = (which == 0) ? busy_a : busy_b;
      t = (which == 0) ? tx_a : tx_b;
      if (s) begin
        nsent++;
        if (first_s < 0) first_s = k;
        else if (second_s < 0) second_s = k;
      end
      if (!b && busy_low < 0) busy_low = k;
      if (k == 2) tx2 = t;
      if (k == 3) tx3 = t;
    end
  endtask

  task automatic test_reset;
    logic stayed_high;
    rst_n = 1'b0;
    #23;
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || sent_a !== 1'b0 || addr_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a tx %b busy %b sent %b addr %b expected 1 0 0 0", tx_a, busy_a, sent_a, addr_a);
    end
    checks++;
    if (tx_b !== 1'b1 || busy_b !== 1'b0 || sent_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b tx %b busy %b sent %b expected 1 0 0", tx_b, busy_b, sent_b);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    stayed_high = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (tx_a !== 1'b1 || tx_b !== 1'b1 || busy_a !== 1'b0 || sent_a !== 1'b0) stayed_high = 1'b0;
    end
    checks++;
    if (stayed_high !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset line not quiet: got %b expected 1", stayed_high);
    end
  endtask

  task automatic test_crlf_digit;
    int f, s2, n, bl;
    logic t2, t3;
    q_a.push_back(8'h37); q_a.push_back(8'h0D); q_a.push_back(8'h0A);
    pulse(0, 8'h07);
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL crlf_busy_rise got %b expected 1", busy_a); end
    watch(0, 130, f, s2, n, bl, t2, t3);
    checks++;
    if (t2 !== 1'b1 || t3 !== 1'b0) begin
      errors++;
      $display("FAIL crlf_tx_fall tx@N+2 %b tx@N+3 %b expected 1 0", t2, t3);
    end
    checks++;
    if (f != 123 || n != 1) begin
      errors++;
      $display("FAIL crlf_sent first at N+%0d count %0d expected N+123 count 1", f, n);
    end
    checks++;
    if (bl != 123) begin errors++; $display("FAIL crlf_busy_fall at N+%0d expected N+123", bl); end
    checks++;
    if (q_a.size() != 0) begin errors++; $display("FAIL crlf_frames left %0d expected 0", q_a.size()); end
  endtask

  task automatic test_no_crlf;
    int f, s2, n, bl;
    logic t2, t3;
    q_b.push_back(8'h3F);
    pulse(1, 8'h0C);
    watch(1, 50, f, s2, n, bl, t2, t3);
    checks++;
    if (f != 43 || n != 1 || bl != 43) begin
      errors++;
      $display("FAIL raw_q sent N+%0d count %0d busy_low N+%0d expected 43 1 43", f, n, bl);
    end
    q_b.push_back(8'h35);
    pulse(1, 8'hA5);
    watch(1, 50, f, s2, n, bl, t2, t3);
    checks++;
    if (f != 43 || n != 1 || t3 !== 1'b0) begin
      errors++;
      $display("FAIL raw_5 sent N+%0d count %0d tx@N+3 %b expected 43 1 0", f, n, t3);
    end
    checks++;
    if (q_b.size() != 0) begin errors++; $display("FAIL raw_frames left %0d expected 0", q_b.size()); end
  endtask

  task automatic test_back_to_back;
    int f, s2, n, bl;
    logic t2, t3;
    q_a.push_back(8'h32); q_a.push_back(8'h0D); q_a.push_back(8'h0A);
    q_a.push_back(8'h39); q_a.push_back(8'h0D); q_a.push_back(8'h0A);
    pulse(0, 8'h02);
    repeat (19) @(posedge clk);
    #1;
    pulse(0, 8'h09);
    watch(0, 240, f, s2, n, bl, t2, t3);
    checks++;
    if (f != 103 || s2 != 226 || n != 2 || bl != 226) begin
      errors++;
      $display("FAIL b2b sent N+%0d,N+%0d count %0d busy_low %0d expected 103 226 2 226", f, s2, n, bl);
    end
    checks++;
    if (q_a.size() != 0) begin errors++; $display("FAIL b2b_frames left %0d expected 0", q_a.size()); end

    q_a.push_back(8'h31); q_a.push_back(8'h0D); q_a.push_back(8'h0A);
    q_a.push_back(8'h36); q_a.push_back(8'h0D); q_a.push_back(8'h0A);
    pulse(0, 8'h01);
    repeat (15) @(posedge clk);
    #1;
    pulse(0, 8'h04);
    repeat (15) @(posedge clk);
    #1;
    pulse(0, 8'h06);
    watch(0, 260, f, s2, n, bl, t2, t3);
    checks++;
    if (f != 91 || s2 != 214 || n != 2 || bl != 214) begin
      errors++;
      $display("FAIL collapse sent N+%0d,N+%0d count %0d busy_low %0d expected 91 214 2 214", f, s2, n, bl);
    end
    checks++;
    if (q_a.size() != 0) begin errors++; $display("FAIL collapse_frames left %0d expected 0", q_a.size()); end
  endtask

  task automatic test_reset_mid_frame;
    int f, s2, n, bl;
    logic t2, t3;
    q_a.push_back(8'h33); q_a.push_back(8'h0D); q_a.push_back(8'h0A);
    pulse(0, 8'h03);
    repeat (16) @(posedge clk);
    #1;
    checks++;
    if (tx_a !== 1'b0) begin errors++; $display("FAIL midframe_bit2 tx %b expected 0", tx_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset tx %b busy %b expected 1 0", tx_a, busy_a);
    end
    q_a.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    watch(0, 60, f, s2, n, bl, t2, t3);
    checks++;
    if (n != 0 || busy_a !== 1'b0 || tx_a !== 1'b1) begin
      errors++;
      $display("FAIL abandoned sent count %0d busy %b tx %b expected 0 0 1", n, busy_a, tx_a);
    end
    q_a.push_back(8'h38); q_a.push_back(8'h0D); q_a.push_back(8'h0A);
    pulse(0, 8'h08);
    watch(0, 130, f, s2, n, bl, t2, t3);
    checks++;
    if (f != 123 || n != 1 || t3 !== 1'b0) begin
      errors++;
      $display("FAIL after_reset sent N+%0d count %0d tx@N+3 %b expected 123 1 0", f, n, t3);
    end
    checks++;
    if (q_a.size() != 0) begin errors++; $display("FAIL after_reset_frames left %0d expected 0", q_a.size()); end
  endtask

  initial begin
    done_a = 1'b0; done_b = 1'b0;
    wdata_a = 8'h00; wdata_b = 8'h00;
    test_reset();
    test_crlf_digit();
    test_no_crlf();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (10) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
